// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle instruction control block.
//   - state_t       : FSM state encoding (IDLE, DECODE, EXECUTE, WRITEBACK)
//   - DEF_*         : default widths, the default multi-cycle alu_op code and
//                     its execute length
package multicycle_control_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  localparam int         DEF_FUNC_W       = 6;
  localparam int         DEF_ALUOP_W      = 4;
  localparam logic [3:0] DEF_MULTI_OP     = 4'b1011;
  localparam int         DEF_MULTI_CYCLES = 4;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction handshake and datapath-control bundle.
//   instr_valid/instr_ready : instruction handshake
//   insmsb, func            : instruction fields (immediate flag, function)
//   alu_src, alu_op, imm_sel: registered datapath controls
//   reg_write, pc_write     : one-cycle writeback strobes
//   busy, illegal           : status (instruction in flight, rejected encoding)
// slave  : the control block side
// master : the instruction source / datapath side
interface multicycle_control_if #(
  parameter int FUNC_W  = 6,
  parameter int ALUOP_W = 4
) ();
  logic               instr_valid;
  logic               instr_ready;
  logic               insmsb;
  logic [FUNC_W-1:0]  func;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               imm_sel;
  logic               reg_write;
  logic               pc_write;
  logic               busy;
  logic               illegal;

  modport slave (
    input  instr_valid, insmsb, func,
    output instr_ready, alu_src, alu_op, imm_sel, reg_write, pc_write, busy, illegal
  );

  modport master (
    output instr_valid, insmsb, func,
    input  instr_ready, alu_src, alu_op, imm_sel, reg_write, pc_write, busy, illegal
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational instruction decoder.
//   in : insmsb (immediate form), func (function field)
//   out: alu_src, alu_op, imm_sel, illegal (reserved R-type encoding),
//        is_multi (alu_op needs the multi-cycle execute)
module multicycle_decode #(
  parameter int                 FUNC_W   = 6,
  parameter int                 ALUOP_W  = 4,
  parameter logic [ALUOP_W-1:0] MULTI_OP = '1
) (
  input  logic               insmsb,
  input  logic [FUNC_W-1:0]  func,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               imm_sel,
  output logic               illegal,
  output logic               is_multi
);

  always_comb begin
    alu_op   = {func[FUNC_W-1], func[ALUOP_W-2:0]};
    imm_sel  = insmsb;
    // Immediate forms always take the extended operand; R-types use the
    // inverted func MSB to select it.
    alu_src  = insmsb | ~func[FUNC_W-1];
    // The middle func bits are reserved for R-types and must be zero.
    illegal  = ~insmsb & (|func[FUNC_W-2:ALUOP_W-1]);
    is_multi = (alu_op == MULTI_OP);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction control FSM.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : multicycle_control_if.slave -- instruction handshake in,
//                registered datapath controls and status out
// One instruction is accepted in IDLE, decoded over two DECODE cycles
// (field latch -> decode register -> committed controls), executed for one
// cycle or MULTI_CYCLES cycles, and retired with a one-cycle WRITEBACK strobe.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int                 FUNC_W       = DEF_FUNC_W,
  parameter int                 ALUOP_W      = DEF_ALUOP_W,
  parameter logic [ALUOP_W-1:0] MULTI_OP     = ALUOP_W'(DEF_MULTI_OP),
  parameter int                 MULTI_CYCLES = DEF_MULTI_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.slave bus
);

  localparam int CNT_W = $clog2(MULTI_CYCLES);

  typedef struct packed {
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               imm_sel;
    logic               illegal;
    logic               is_multi;
  } dec_t;

  state_t             state_q, state_d;
  logic               ph_q, ph_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, commit;

  logic               insmsb_p0;
  logic [FUNC_W-1:0]  func_p0;
  dec_t               dec_c, dec_p1;

  logic               dc_alu_src, dc_imm_sel, dc_illegal, dc_is_multi;
  logic [ALUOP_W-1:0] dc_alu_op;

  logic               ready_q, busy_q, reg_write_q, pc_write_q, illegal_q;
  logic               alu_src_q, imm_sel_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               illegal_d;

  multicycle_decode #(
    .FUNC_W   (FUNC_W),
    .ALUOP_W  (ALUOP_W),
    .MULTI_OP (MULTI_OP)
  ) u_decode (
    .insmsb   (insmsb_p0),
    .func     (func_p0),
    .alu_src  (dc_alu_src),
    .alu_op   (dc_alu_op),
    .imm_sel  (dc_imm_sel),
    .illegal  (dc_illegal),
    .is_multi (dc_is_multi)
  );

  assign dec_c  = {dc_alu_src, dc_alu_op, dc_imm_sel, dc_illegal, dc_is_multi};
  assign accept = (state_q == S_IDLE) && bus.instr_valid;

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    commit    = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d = S_DECODE;
          ph_d    = 1'b0;
        end
      end
      S_DECODE: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d   = 1'b0;
          commit = 1'b1;
          if (dec_p1.illegal) begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end else begin
            state_d = S_EXECUTE;
            if (dec_p1.is_multi) cnt_d = CNT_W'(MULTI_CYCLES - 1);
          end
        end
      end
      S_EXECUTE: begin
        // A loaded counter of N-1 gives exactly N execute cycles.
        if (dec_p1.is_multi && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);
        else                                  state_d = S_WRITEBACK;
      end
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Stage p0: instruction fields latched at the accepting edge.
  // Stage p1: decoder output registered at the first DECODE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insmsb_p0 <= 1'b0;
      func_p0   <= '0;
      dec_p1    <= '0;
    end else begin
      if (accept) begin
        insmsb_p0 <= bus.insmsb;
        func_p0   <= bus.func;
      end
      if ((state_q == S_DECODE) && !ph_q) dec_p1 <= dec_c;
    end
  end

  // Controls commit at the DECODE exit edge; status outputs follow next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ph_q        <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      reg_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      illegal_q   <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      imm_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      reg_write_q <= (state_d == S_WRITEBACK);
      pc_write_q  <= (state_d == S_WRITEBACK);
      illegal_q   <= illegal_d;
      if (commit) begin
        alu_src_q <= dec_p1.alu_src;
        alu_op_q  <= dec_p1.alu_op;
        imm_sel_q <= dec_p1.imm_sel;
      end
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.pc_write    = pc_write_q;
  assign bus.illegal     = illegal_q;
  assign bus.alu_src     = alu_src_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.imm_sel     = imm_sel_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: inputs driven and outputs sampled
// on the falling edge; edge numbers below count rising edges from acceptance.
module tb_multicycle_control;

  localparam int FUNC_W  = 6;
  localparam int ALUOP_W = 4;
  localparam int MC      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt, rw_cnt, rw_at, strobe_cnt;

  multicycle_control_if #(.FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W)) bus ();

  multicycle_control #(
    .FUNC_W       (FUNC_W),
    .ALUOP_W      (ALUOP_W),
    .MULTI_OP     (4'b1011),
    .MULTI_CYCLES (MC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single accepting edge; returns at the
  // falling edge after edge 0.
  task automatic send(input logic ins, input logic [FUNC_W-1:0] f);
    bus.instr_valid = 1'b1;
    bus.insmsb      = ins;
    bus.func        = f;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.insmsb      = 1'b0;
    bus.func        = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",   32'(bus.instr_ready), 32'd1);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_rw",      32'(bus.reg_write),   32'd0);
    chk("rst_pcw",     32'(bus.pc_write),    32'd0);
    chk("rst_illegal", 32'(bus.illegal),     32'd0);
    chk("rst_aluop",   32'(bus.alu_op),      32'd0);
    chk("rst_alusrc",  32'(bus.alu_src),     32'd0);
    chk("rst_immsel",  32'(bus.imm_sel),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // R-type single-cycle 100010 -> alu_op 1010
    send(1'b0, 6'b100010);
    chk("r_busy_e0",  32'(bus.busy),        32'd1);
    chk("r_ready_e0", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    chk("r_rw_e1",    32'(bus.reg_write),   32'd0);
    @(negedge clk);
    chk("r_aluop_e2", 32'(bus.alu_op),      32'hA);
    chk("r_alusrc",   32'(bus.alu_src),     32'd0);
    chk("r_immsel",   32'(bus.imm_sel),     32'd0);
    chk("r_rw_e2",    32'(bus.reg_write),   32'd0);
    @(negedge clk);
    chk("r_rw_e3",    32'(bus.reg_write),   32'd1);
    chk("r_pcw_e3",   32'(bus.pc_write),    32'd1);
    chk("r_ready_e3", 32'(bus.instr_ready), 32'd0);
    @(negedge clk);
    chk("r_rw_e4",    32'(bus.reg_write),   32'd0);
    chk("r_ready_e4", 32'(bus.instr_ready), 32'd1);
    chk("r_busy_e4",  32'(bus.busy),        32'd0);

    // Immediate 011001 -> alu_op 0001, alu_src 1, imm_sel 1
    send(1'b1, 6'b011001);
    repeat (2) @(negedge clk);
    chk("i_aluop",    32'(bus.alu_op),      32'h1);
    chk("i_alusrc",   32'(bus.alu_src),     32'd1);
    chk("i_immsel",   32'(bus.imm_sel),     32'd1);
    chk("i_illegal",  32'(bus.illegal),     32'd0);
    @(negedge clk);
    chk("i_rw_e3",    32'(bus.reg_write),   32'd1);
    @(negedge clk);
    chk("i_ready_e4", 32'(bus.instr_ready), 32'd1);

    // Multi-cycle 100011 -> alu_op 1011, with valid toggling and func
    // changing after acceptance
    send(1'b0, 6'b100011);
    busy_cnt = 0;
    rw_cnt   = 0;
    rw_at    = -1;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.reg_write === 1'b1) begin
        rw_cnt++;
        rw_at = k;
      end
      if (k == 2) chk("m_aluop_e2", 32'(bus.alu_op), 32'hB);
      if (k == 5) chk("m_aluop_e5", 32'(bus.alu_op), 32'hB);
      if (k < 3) begin
        bus.instr_valid = (k % 2 == 0);
        bus.func        = 6'b000000;
      end else begin
        bus.instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("m_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("m_rw_pulses",   32'(rw_cnt),   32'd1);
    chk("m_rw_edge",     32'(rw_at),    32'd6);
    chk("m_hold_aluop",  32'(bus.alu_op),      32'hB);
    chk("m_ready_end",   32'(bus.instr_ready), 32'd1);

    // Illegal 011000, followed by a legal R-type accepted in the illegal cycle
    send(1'b0, 6'b011000);
    chk("il_rw_e0",      32'(bus.reg_write),   32'd0);
    @(negedge clk);
    chk("il_illegal_e1", 32'(bus.illegal),     32'd0);
    chk("il_rw_e1",      32'(bus.reg_write),   32'd0);
    @(negedge clk);
    chk("il_illegal_e2", 32'(bus.illegal),     32'd1);
    chk("il_ready_e2",   32'(bus.instr_ready), 32'd1);
    chk("il_busy_e2",    32'(bus.busy),        32'd0);
    chk("il_rw_e2",      32'(bus.reg_write),   32'd0);
    chk("il_pcw_e2",     32'(bus.pc_write),    32'd0);
    send(1'b0, 6'b100010);
    chk("il_illegal_e3", 32'(bus.illegal),     32'd0);
    chk("il_next_busy",  32'(bus.busy),        32'd1);
    repeat (2) @(negedge clk);
    chk("il_next_aluop", 32'(bus.alu_op),      32'hA);
    chk("il_next_rw0",   32'(bus.reg_write),   32'd0);
    @(negedge clk);
    chk("il_next_rw",    32'(bus.reg_write),   32'd1);
    @(negedge clk);
    chk("il_next_ready", 32'(bus.instr_ready), 32'd1);

    // Back-to-back: valid held, so the return to IDLE accepts again
    bus.instr_valid = 1'b1;
    bus.insmsb      = 1'b0;
    bus.func        = 6'b100010;
    @(negedge clk);
    chk("bb_busy_e0",   32'(bus.busy),        32'd1);
    repeat (3) @(negedge clk);
    chk("bb_rw_e3",     32'(bus.reg_write),   32'd1);
    @(negedge clk);
    chk("bb_ready_e4",  32'(bus.instr_ready), 32'd1);
    @(negedge clk);
    chk("bb_busy_e5",   32'(bus.busy),        32'd1);
    chk("bb_ready_e5",  32'(bus.instr_ready), 32'd0);
    bus.instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bb_ready_end", 32'(bus.instr_ready), 32'd1);

    // Reset asserted mid-EXECUTE drops the instruction
    send(1'b0, 6'b100011);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_ready", 32'(bus.instr_ready), 32'd1);
    chk("mr_busy",  32'(bus.busy),        32'd0);
    chk("mr_aluop", 32'(bus.alu_op),      32'd0);
    chk("mr_rw",    32'(bus.reg_write),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if ((bus.reg_write === 1'b1) || (bus.pc_write === 1'b1)) strobe_cnt++;
    end
    chk("mr_no_strobe", 32'(strobe_cnt),       32'd0);
    chk("mr_idle",      32'(bus.instr_ready),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
